pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised next-PC/step engine for the MIPS core: owns PC, a clock-enable step generator
//  (replaces the toggled derived clock), interrupt sync/priority and exception vectoring.
//  Sits between Control (pc_src) and ROM/RegFile; every other core register updates only when step=1.
// PARAMETERS
//  DIV          2             clk cycles per step in free-run (>=1)
//  N_IRQ        2             interrupt channels (1..8)
//  SYNC_STAGES  2             irq synchroniser depth (>=2)
//  RESET_VEC    32'h8000_0000 PC after reset
//  ILLOP_VEC    32'h8000_0004 illegal-op vector
//  XADR_VEC     32'h8000_0008 bad-address vector
//  IRQ_BASE     32'h8000_000C IRQ k vector = IRQ_BASE + 4*k
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-high reset
//  single_step  in   1       0 free-run, 1 one step per step_req rising edge
//  step_req     in   1       debounced button, async to clk
//  pc_src       in   3       from Control: 0 +4, 1 branch, 2 jump, 3 jr, 4 ILLOP, 5 XADR, 6-7 rsvd(+4)
//  branch_taken in   1       ALU_out[0]
//  branch_off   in   32      sign-extended imm (not yet shifted)
//  jump_index   in   26      Instruction[25:0]
//  jr_target    in   32      Databus1
//  irq          in   N_IRQ   level requests from Peripheral, async
//  irq_mask     in   N_IRQ   1 = enabled
//  step         out  1       one-clk enable: commit this instruction
//  pc           out  32      current PC
//  pc_plus_4    out  32      {pc[31], pc[30:0]+4}
//  irq_taken    out  1       pulse with step when IRQ vectoring happens
//  irq_id       out  3       channel taken (valid with irq_taken)
//  epc          out  32      see CONFIGURATION
// BEHAVIOUR
//  Reset: pc=RESET_VEC, step=0, irq_taken=0, irq_id=0, epc=0, divider=0, sync flops=0.
//  Free-run: divider counts 0..DIV-1; step=1 on the clk where count==DIV-1 (DIV=1: step every clk).
//  Single-step: step_req 2-flop synced + edge-detected; each rising edge gives exactly one step
//   on the following clk; divider held at 0; edges arriving while step=1 are not lost (1-deep latch).
//  Mode switch takes effect at the next divider wrap; no spurious or double step.
//  PC updates only on clk edges with step=1; otherwise all outputs hold (irq_taken=0).
//  Next-PC priority (highest first):
//   1 pc_src=4 -> ILLOP_VEC; pc_src=5 -> XADR_VEC
//   2 IRQ: pc[31]==0 and (pend & irq_mask)!=0 -> IRQ_BASE+4*k, k = lowest set index;
//     irq_taken=1, irq_id=k for that step; overrides pc_src 0-3
//   3 pc_src 1: branch_taken ? pc_plus_4 + (branch_off<<2) (32-bit, wraps mod 2^32) : pc_plus_4
//   4 pc_src 2: {pc_plus_4[31:28], jump_index, 2'b00}; pc_src 3: jr_target (only path clearing pc[31])
//   5 pc_src 0/6/7: pc_plus_4; pc[30:0] wraps 7FFF_FFFC->0, pc[31] preserved
//  pend = irq after SYNC_STAGES flops; a request asserted on the step edge is seen at the next step.
//  Kernel mode (pc[31]=1) blocks IRQs; pending stays level, taken after jr back to user space.
//  Reset mid-step aborts: PC forced to RESET_VEC on the same edge, no irq_taken.
// CONFIGURATION
//  PC_SEQ_EPC_EN defined: epc loads the address to resume at (pc for IRQ, pc_plus_4 for
//   ILLOP/XADR) on every vectoring step; holds otherwise.
//  Not defined: no EPC register; epc tied to 32'h0; software relies on $26 link via RegDst.
// STRUCTURE
//  pc_seq_pkg: PCSRC_* encodings (3-bit), default vector constants, KERNEL_BIT=31.
//  One sub-module: step_gen (divider + step_req sync/edge + single-step latch) -> step.
//  Top: PC register, next-PC mux, irq sync chain, priority encoder, optional EPC.
// TESTING
//  reset, DIV=2, pc_src=0 -> pc 8000_0000, 8000_0004 on each 2nd clk; step 1 clk wide
//  pc=0000_0100, pc_src=1, taken, off=FFFF_FFFE -> pc=0000_00FC; not taken -> 0000_0104
//  pc=0000_0040, irq=2'b11, mask=2'b10 -> after sync, next step pc=8000_0010, irq_id=1, epc=0000_0040 (EPC_EN)
//  same irq with pc=8000_0020 -> no IRQ taken; pc_src=3, jr=0000_0044 -> pc=0000_0044, next step IRQ taken
//  pc_src=4 with IRQ pending -> pc=8000_0004, irq_taken=0; pc=7FFF_FFFC, pc_src=0 -> 0000_0000
//  single_step=1, three step_req pulses 20 clks apart -> exactly 3 steps; reset mid-run -> 8000_0000

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - pc_src encodings, default vectors and IRQ priority helper for pc_sequencer
package pc_seq_pkg;

    localparam logic [2:0] PCSRC_SEQ    = 3'd0;
    localparam logic [2:0] PCSRC_BRANCH = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_JR     = 3'd3;
    localparam logic [2:0] PCSRC_ILLOP  = 3'd4;
    localparam logic [2:0] PCSRC_XADR   = 3'd5;

    localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;
    localparam logic [31:0] DEF_IRQ_BASE  = 32'h8000_000C;

    localparam int KERNEL_BIT = 31;

    // Index of the lowest set bit; lower channel numbers win
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/pc_sequencer_step_gen.sv
// rtl/pc_sequencer_step_gen.sv - commit-enable generator: free-run divider or debounced single-step
module pc_sequencer_step_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic single_step,
    input  logic step_req,
    output logic step
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          req_s1_q, req_s2_q, req_d_q, rise;
    logic          mode_ss_q, mode_nxt;
    logic          pend_q, pend_nxt;
    logic          step_q, step_nxt;
    logic          fire;

    // Two-flop synchroniser for the button plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
            req_d_q  <= 1'b0;
        end else begin
            req_s1_q <= step_req;
            req_s2_q <= req_s1_q;
            req_d_q  <= req_s2_q;
        end
    end

    assign rise = req_s2_q & ~req_d_q;

    // Mode only changes at a free-run wrap or when single-step is idle, so no step is doubled or dropped
    always_comb begin
        mode_nxt = mode_ss_q;
        if ((!mode_ss_q && step_q) || (mode_ss_q && !step_q && !pend_q)) begin
            mode_nxt = single_step;
        end
        fire = !step_q && (rise || pend_q);
        if (mode_nxt) begin
            cnt_nxt  = '0;
            step_nxt = fire;
            pend_nxt = fire ? 1'b0 : (pend_q | rise);
        end else begin
            cnt_nxt  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            step_nxt = (cnt_nxt == CNT_LAST);
            pend_nxt = 1'b0;
        end
    end

    // Divider, mode, one-deep request latch and registered step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            mode_ss_q <= 1'b0;
            pend_q    <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_nxt;
            mode_ss_q <= mode_nxt;
            pend_q    <= pend_nxt;
            step_q    <= step_nxt;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, next-PC priority mux, IRQ sync/priority; EPC under PC_SEQ_EPC_EN
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          DIV         = 2,
    parameter int          N_IRQ       = 2,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_VEC   = DEF_RESET_VEC,
    parameter logic [31:0] ILLOP_VEC   = DEF_ILLOP_VEC,
    parameter logic [31:0] XADR_VEC    = DEF_XADR_VEC,
    parameter logic [31:0] IRQ_BASE    = DEF_IRQ_BASE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             single_step,
    input  logic             step_req,
    input  logic [2:0]       pc_src,
    input  logic             branch_taken,
    input  logic [31:0]      branch_off,
    input  logic [25:0]      jump_index,
    input  logic [31:0]      jr_target,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    output logic             step,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus_4,
    output logic             irq_taken,
    output logic [2:0]       irq_id,
    output logic [31:0]      epc
);

    logic                              step_i;
    logic [SYNC_STAGES-1:0][N_IRQ-1:0] irq_sync_q;
    logic [N_IRQ-1:0]                  pend, irq_req;
    logic [7:0]                        irq_req8;
    logic [2:0]                        irq_k;
    logic                              irq_hit, take_irq;
    logic [31:0]                       pc_q, pc_p4, pc_nxt, irq_vec;
    logic                              irq_taken_q;
    logic [2:0]                        irq_id_q;

    pc_sequencer_step_gen #(.DIV(DIV)) u_step_gen (
        .clk         (clk),
        .reset       (reset),
        .single_step (single_step),
        .step_req    (step_req),
        .step        (step_i)
    );

    // Interrupt request synchroniser chain; the last stage is the pending level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_sync_q <= '0;
        else       irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irq};
    end

    assign pend     = irq_sync_q[SYNC_STAGES-1];
    assign irq_req  = pend & irq_mask;
    assign irq_req8 = 8'(irq_req);
    assign irq_k    = lowest_set(irq_req8);
    assign irq_hit  = !pc_q[KERNEL_BIT] && (irq_req != '0);
    assign irq_vec  = IRQ_BASE + {27'd0, irq_k, 2'b00};
    assign pc_p4    = {pc_q[31], pc_q[30:0] + 31'd4};

    // Next-PC selection: exceptions, then interrupts, then Control's choice
    always_comb begin
        pc_nxt   = pc_p4;
        take_irq = 1'b0;
        if (pc_src == PCSRC_ILLOP) begin
            pc_nxt = ILLOP_VEC;
        end else if (pc_src == PCSRC_XADR) begin
            pc_nxt = XADR_VEC;
        end else if (irq_hit) begin
            pc_nxt   = irq_vec;
            take_irq = 1'b1;
        end else begin
            case (pc_src)
                PCSRC_BRANCH: pc_nxt = branch_taken ? pc_p4 + (branch_off << 2) : pc_p4;
                PCSRC_JUMP:   pc_nxt = {pc_p4[31:28], jump_index, 2'b00};
                PCSRC_JR:     pc_nxt = jr_target;
                PCSRC_SEQ:    pc_nxt = pc_p4;
                default:      pc_nxt = pc_p4;
            endcase
        end
    end

    // PC and interrupt report advance only on commit cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_VEC;
            irq_taken_q <= 1'b0;
            irq_id_q    <= 3'd0;
        end else begin
            irq_taken_q <= step_i && take_irq;
            if (step_i) pc_q <= pc_nxt;
            if (step_i && take_irq) irq_id_q <= irq_k;
        end
    end

`ifdef PC_SEQ_EPC_EN
    logic [31:0] epc_q, epc_nxt;
    logic        vectoring;

    // Resume address: the interrupted PC for IRQs, the following PC for exceptions
    always_comb begin
        vectoring = 1'b1;
        epc_nxt   = pc_p4;
        if (pc_src == PCSRC_ILLOP || pc_src == PCSRC_XADR) begin
            epc_nxt = pc_p4;
        end else if (irq_hit) begin
            epc_nxt = pc_q;
        end else begin
            vectoring = 1'b0;
        end
    end

    // EPC captures on every vectoring commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  epc_q <= 32'h0;
        else if (step_i && vectoring) epc_q <= epc_nxt;
    end

    assign epc = epc_q;
`else
    assign epc = 32'h0;
`endif

    assign step      = step_i;
    assign pc        = pc_q;
    assign pc_plus_4 = pc_p4;
    assign irq_taken = irq_taken_q;
    assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with a behavioural next-PC model
module tb_pc_sequencer;

    localparam int N_IRQ = 2;
    localparam int SS    = 2;
    localparam logic [31:0] RV = 32'h8000_0000;
    localparam logic [31:0] IV = 32'h8000_0004;
    localparam logic [31:0] XV = 32'h8000_0008;
    localparam logic [31:0] IB = 32'h8000_000C;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             single_step = 1'b0;
    logic             step_req = 1'b0;
    logic [2:0]       pc_src = 3'd0;
    logic             branch_taken = 1'b0;
    logic [31:0]      branch_off = 32'h0;
    logic [25:0]      jump_index = 26'h0;
    logic [31:0]      jr_target = 32'h0;
    logic [N_IRQ-1:0] irq = '0;
    logic [N_IRQ-1:0] irq_mask = '0;
    logic             step;
    logic [31:0]      pc, pc_plus_4, epc;
    logic             irq_taken;
    logic [2:0]       irq_id;

    pc_sequencer #(.DIV(2), .N_IRQ(N_IRQ), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .reset        (reset),
        .single_step  (single_step),
        .step_req     (step_req),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump_index   (jump_index),
        .jr_target    (jr_target),
        .irq          (irq),
        .irq_mask     (irq_mask),
        .step         (step),
        .pc           (pc),
        .pc_plus_4    (pc_plus_4),
        .irq_taken    (irq_taken),
        .irq_id       (irq_id),
        .epc          (epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [2:0]  id;
        logic [31:0] epc;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_fail = 0;
    int               step_cnt = 0;
    int               clk_cnt = 0;
    int               last_step_cyc = 0;
    logic             ss_req = 1'b0;
    logic [31:0]      m_pc = RV;
    logic [31:0]      m_epc = 32'h0;
    logic [2:0]       m_id = 3'd0;
    logic [31:0]      hold_pc = RV;
    logic [N_IRQ-1:0] hist [SS+1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    // Delay line of sampled irq levels: entry i holds irq as seen i+1 clock edges ago
    always @(posedge clk) begin
        clk_cnt <= clk_cnt + 1;
        if (reset) begin
            for (int i = 0; i <= SS; i++) hist[i] <= '0;
        end else begin
            for (int i = SS; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= irq;
        end
    end

    // Wait for a commit cycle, drive its inputs and queue the reference outcome
    task automatic do_step(input logic [2:0] src, input logic tk, input logic [31:0] off,
                           input logic [25:0] ji, input logic [31:0] jr,
                           input logic [N_IRQ-1:0] iv, input logic [N_IRQ-1:0] mv);
        int               w = 0;
        int               k = 0;
        exp_t             e;
        logic [31:0]      p4;
        logic [N_IRQ-1:0] req;
        @(negedge clk);
        while (step !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (step !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL step_timeout: no step within 60 clks");
            return;
        end
        last_step_cyc = clk_cnt;
        pc_src = src; branch_taken = tk; branch_off = off; jump_index = ji; jr_target = jr;
        irq = iv; irq_mask = mv; single_step = ss_req;
        req = hist[SS-1] & mv;
        p4  = {m_pc[31], m_pc[30:0] + 31'd4};
        e.tk = 1'b0; e.id = m_id; e.epc = m_epc;
        if (src == 3'd4) begin
            e.pc = IV; e.epc = p4;
        end else if (src == 3'd5) begin
            e.pc = XV; e.epc = p4;
        end else if (!m_pc[31] && req != '0) begin
            for (int i = N_IRQ - 1; i >= 0; i--) if (req[i]) k = i;
            e.pc = IB + 32'(4 * k); e.tk = 1'b1; e.id = 3'(k); e.epc = m_pc;
        end else if (src == 3'd1) begin
            e.pc = tk ? p4 + off * 32'd4 : p4;
        end else if (src == 3'd2) begin
            e.pc = {p4[31:28], ji, 2'b00};
        end else if (src == 3'd3) begin
            e.pc = jr;
        end else begin
            e.pc = p4;
        end
`ifndef PC_SEQ_EPC_EN
        e.epc = 32'h0;
`endif
        m_pc = e.pc; m_id = e.id; m_epc = e.epc;
        sb_q.push_back(e);
    endtask

    // Monitor: each commit edge pops one expectation; idle edges must hold state
    initial begin : monitor
        logic s;
        exp_t e;
        forever begin
            @(negedge clk);
            s = step;
            @(posedge clk);
            #1;
            if (reset) begin
                hold_pc = RV;
                continue;
            end
            if (s) begin
                step_cnt++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_step: pc=%08h with no expected entry", pc);
                end else begin
                    e = sb_q.pop_front();
                    chk("pc", pc, e.pc);
                    chk("pc_plus_4", pc_plus_4, {e.pc[31], e.pc[30:0] + 31'd4});
                    chk("irq_taken", 32'(irq_taken), 32'(e.tk));
                    chk("irq_id", 32'(irq_id), 32'(e.id));
                    chk("epc", epc, e.epc);
                    hold_pc = e.pc;
                end
            end else begin
                chk("irq_taken_idle", 32'(irq_taken), 32'd0);
                chk("pc_hold", pc, hold_pc);
            end
        end
    end

    initial begin : stim
        int          a, w, c0;
        logic [2:0]  src;
        logic [1:0]  iv, mv;
        logic [31:0] jr;

        repeat (3) @(negedge clk);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_pc", pc, RV);
        chk("rst_irq_taken", 32'(irq_taken), 32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);
        chk("rst_epc", epc, 32'h0);
        reset = 1'b0;

        do_step(3'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        a = last_step_cyc;
        for (int i = 0; i < 5; i++) do_step(3'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        chk("freerun_spacing", 32'(last_step_cyc - a), 32'd10);

        do_step(3'd3, 0, 0, 0, 32'h0000_0100, 2'b00, 2'b00);
        do_step(3'd1, 1, 32'hFFFF_FFFE, 0, 0, 2'b00, 2'b00);
        do_step(3'd3, 0, 0, 0, 32'h0000_0100, 2'b00, 2'b00);
        do_step(3'd1, 0, 32'hFFFF_FFFE, 0, 0, 2'b00, 2'b00);
        do_step(3'd3, 0, 0, 0, 32'h0000_0040, 2'b11, 2'b10);
        do_step(3'd0, 0, 0, 0, 0, 2'b11, 2'b10);
        do_step(3'd2, 0, 0, 26'h000_0008, 0, 2'b11, 2'b10);
        do_step(3'd0, 0, 0, 0, 0, 2'b11, 2'b10);
        do_step(3'd3, 0, 0, 0, 32'h0000_0044, 2'b11, 2'b10);
        do_step(3'd0, 0, 0, 0, 0, 2'b11, 2'b10);
        do_step(3'd3, 0, 0, 0, 32'h0000_0050, 2'b11, 2'b10);
        do_step(3'd4, 0, 0, 0, 0, 2'b11, 2'b10);
        do_step(3'd3, 0, 0, 0, 32'h7FFF_FFFC, 2'b00, 2'b10);
        do_step(3'd0, 0, 0, 0, 0, 2'b00, 2'b10);

        iv = 2'b00; mv = 2'b00;
        for (int i = 0; i < 150; i++) begin
            src = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) iv = 2'($urandom);
            if ($urandom_range(0, 3) == 0) mv = 2'($urandom);
            jr = {1'($urandom_range(0, 1)), 29'($urandom), 2'b00};
            do_step(src, 1'($urandom), 32'($urandom), 26'($urandom), jr, iv, mv);
        end

        w = 0;
        @(negedge clk);
        while (step !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("reset_wait_step", 32'(step), 32'd1);
        #1 reset = 1'b1;
        #2;
        chk("midrun_rst_pc", pc, RV);
        chk("midrun_rst_irq_taken", 32'(irq_taken), 32'd0);
        chk("midrun_rst_step", 32'(step), 32'd0);
        m_pc = RV; m_id = 3'd0; m_epc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_step(3'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        do_step(3'd0, 0, 0, 0, 0, 2'b00, 2'b00);
        ss_req = 1'b1;
        do_step(3'd0, 0, 0, 0, 0, 2'b00, 2'b00);

        repeat (4) @(negedge clk);
        c0 = step_cnt;
        fork
            begin
                for (int p = 0; p < 3; p++) begin
                    repeat (20) @(negedge clk);
                    step_req = 1'b1;
                    repeat (4) @(negedge clk);
                    step_req = 1'b0;
                end
            end
            begin
                for (int p = 0; p < 3; p++) do_step(3'd0, 0, 0, 0, 0, 2'b00, 2'b00);
            end
        join
        repeat (30) @(negedge clk);
        chk("single_step_count", 32'(step_cnt - c0), 32'd3);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
